// File: rtl/add64_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : add64_seq                                                    |
// | Description : 64-bit add sequencer. Drives an external 32-bit clocked      |
// |               adder twice per operation (low words, then high words with   |
// |               the low carry) and recombines the halves into a 64-bit sum.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module add64_seq #(
    parameter int ADD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    output logic [31:0] add_in1,
    output logic [31:0] add_in2,
    output logic        add_cin,
    input  logic [31:0] add_sum,
    input  logic        add_cout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] sum,
    output logic        cout
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_LO   = 2'd1;
    localparam logic [1:0] c_HI   = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    // The wait counter is cleared on entry to LO/HI and bumped every cycle, so
    // the capture edge is the one where it would step from ADD_LAT-1 to ADD_LAT.
    localparam logic [3:0] c_CNT_LAST = 4'(ADD_LAT - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [3:0]  r_cnt;
    logic [63:0] r_a;
    logic [63:0] r_b;
    logic        r_cin;
    logic        r_carry_lo;
    logic [63:0] r_sum;
    logic        r_cout;
    logic        w_cnt_hit;

    assign w_cnt_hit = (r_cnt == c_CNT_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; DONE waits for the consumer before returning to IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (in_valid)  w_next_state = c_LO;
            c_LO:    if (w_cnt_hit) w_next_state = c_HI;
            c_HI:    if (w_cnt_hit) w_next_state = c_DONE;
            c_DONE:  if (out_ready) w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // Operand latch, wait counter and half-result capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt      <= 4'd0;
            r_a        <= 64'd0;
            r_b        <= 64'd0;
            r_cin      <= 1'b0;
            r_carry_lo <= 1'b0;
            r_sum      <= 64'd0;
            r_cout     <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    // Operands are taken only on the accepting edge.
                    if (in_valid) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_cin <= cin;
                        r_cnt <= 4'd0;
                    end
                end
                c_LO: begin
                    if (w_cnt_hit) begin
                        r_sum[31:0] <= add_sum;
                        r_carry_lo  <= add_cout;
                        r_cnt       <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                c_HI: begin
                    if (w_cnt_hit) begin
                        r_sum[63:32] <= add_sum;
                        r_cout       <= add_cout;
                        r_cnt        <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: begin
                    // DONE: result held until the consumer takes it.
                end
            endcase
        end
    end

    // Adder operand mux: held for the whole of LO/HI, zero otherwise.
    always_comb begin
        add_in1 = 32'd0;
        add_in2 = 32'd0;
        add_cin = 1'b0;
        case (r_state)
            c_LO: begin
                add_in1 = r_a[31:0];
                add_in2 = r_b[31:0];
                add_cin = r_cin;
            end
            c_HI: begin
                add_in1 = r_a[63:32];
                add_in2 = r_b[63:32];
                add_cin = r_carry_lo;
            end
            default: begin
                add_in1 = 32'd0;
                add_in2 = 32'd0;
                add_cin = 1'b0;
            end
        endcase
    end

    assign in_ready  = (r_state == c_IDLE);
    assign out_valid = (r_state == c_DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;

endmodule
`default_nettype wire

// File: doc/add64_seq.md
# add64_seq

Sequencer that performs 64-bit additions by driving the team's 32-bit clocked carry-lookahead adder twice per operation: low words first, then high words with the captured low-word carry. It sits directly upstream of the 32-bit adder, feeding its operand/carry inputs. It also sits downstream of that adder, recombining the two 32-bit results into one 64-bit result. It has valid/ready handshakes on both the operand side and the result side.

## Interface

Parameters:
- ADD_LAT, default 1: cycles from driving adder inputs until add_sum/add_cout are valid for them; legal range 1..15.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- in_valid  input  1  operand request.
- in_ready  output  1  block can accept operands.
- a  input  64  operand A.
- b  input  64  operand B.
- cin  input  1  carry into bit 0.
- add_in1  output  32  to adder in1.
- add_in2  output  32  to adder in2.
- add_cin  output  1  to adder cin.
- add_sum  input  32  from adder sum.
- add_cout  input  1  from adder cout.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- sum  output  64  (a + b + cin) mod 2^64.
- cout  output  1  carry out of bit 63.

## Operation

- Clocking: one clock (clk); reset synchronous, active-low (rst_n).
- FSM states:
  - IDLE: in_ready=1.
  - LO: adder gets low words.
  - HI: adder gets high words.
  - DONE: out_valid=1.
- IDLE -> LO on in_valid && in_ready. Latch a, b, cin; clear the wait counter.
- LO:
  - Drives add_in1=a[31:0], add_in2=b[31:0], add_cin=cin.
  - Counter increments each cycle.
  - At the edge where the counter reaches ADD_LAT: capture add_sum into sum[31:0] and add_cout into the carry register. Then go to HI and clear the counter.
- HI:
  - Drives add_in1=a[63:32], add_in2=b[63:32], add_cin=captured low carry.
  - At the edge where the counter reaches ADD_LAT: capture add_sum into sum[63:32] and add_cout into cout. Then go to DONE.
- DONE -> IDLE on out_ready. sum and cout hold until then.
- Adder inputs:
  - Held constant for the whole of LO and the whole of HI.
  - Driven to zero in IDLE and DONE.
- Width: all arithmetic is performed by the external adder; the block only concatenates the two halves. Overflow wraps, and the carry is reported on cout.
- Input latching: in_valid while not in IDLE is ignored; operands are latched only on the accepting edge, not sampled afterwards.

## Timing

- Reset (rst_n low at an edge), from the next cycle:
  - state=IDLE; in_ready=1; out_valid=0.
  - sum=0, cout=0.
  - add_in1=0, add_in2=0, add_cin=0.
- Reset mid-operation (LO, HI or DONE) aborts the operation: no out_valid is produced and the result is discarded.
- Accept at edge T0 (state goes LO).
- Low result captured at edge T0+ADD_LAT.
- High result captured and out_valid rises at edge T0+2*ADD_LAT.
- Latency from accept to out_valid is 2*ADD_LAT cycles.
- in_ready and out_valid are decoded from registered state only; there is no combinational path from in_valid or out_ready.
- Minimum issue interval is 2*ADD_LAT+2 cycles: one cycle in IDLE plus the DONE cycle with out_ready=1.
- Backpressure: out_valid, sum and cout are stable while out_ready=0; in_ready stays 0.
- Output handshake at edge Td (out_valid && out_ready): IDLE from Td, so in_ready=1 in the following cycle. No new operand is accepted in the same cycle as the output handshake.

## Test plan

- Basic add, ADD_LAT=1, against a behavioral 32-bit adder model: a=33, b=12, cin=0 -> sum=45, cout=0, out_valid exactly 2 cycles after accept.
- Carry across halves: a=0x0000_0000_FFFF_FFFF, b=1, cin=0 -> sum=0x0000_0001_0000_0000, cout=0. During HI, add_cin=1.
- Full overflow and cin: a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1 -> sum=0, cout=1. Also a=0, b=0, cin=1 -> sum=1, cout=0.
- Backpressure, ADD_LAT=3: a=113, b=121. Hold out_ready=0 for 5 cycles -> out_valid high at accept+6, sum=234 stable throughout, in_ready=0. in_valid pulses with other operands during the hold are ignored.
- Back-to-back with real adder: instantiate the team's 32-bit adder with ADD_LAT equal to its latency. Issue (33,12), (3,12), (13,12) with out_ready=1 -> sums 45, 15, 25 in order. Check issue spacing equals 2*ADD_LAT+2.
- Reset mid-operation: rst_n low for one edge while in HI -> next cycle in_ready=1, out_valid=0, sum=0. A following a=5, b=7 operation -> sum=12.
